// File: rtl/armleocpu_axi2simple_burst_converter.sv
// AXI4 slave to simple register/memory bus converter with burst support.
//
// Accepts one AXI transaction at a time (write or read, arbitrated fairly
// when both are pending) and replays it beat by beat on a simple bus:
// one write or read strobe per beat, with combinational read_data from the
// peripheral. FIXED/INCR/WRAP bursts up to 256 beats are supported.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   axi_aw*/axi_w*/axi_b*   AXI write address/data/response channels
//   axi_ar*/axi_r*          AXI read address/data channels
//   address, write, write_data, write_byteenable, read   simple bus request
//   read_data, address_error, write_error               simple bus response
module armleocpu_axi2simple_burst_converter #(
    parameter int ADDR_WIDTH = 34,
    parameter int ID_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    localparam int DATA_STROBES = DATA_WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    axi_awvalid,
    output logic                    axi_awready,
    input  logic [ID_WIDTH-1:0]     axi_awid,
    input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
    input  logic [7:0]              axi_awlen,
    input  logic [2:0]              axi_awsize,
    input  logic [1:0]              axi_awburst,

    input  logic                    axi_wvalid,
    output logic                    axi_wready,
    input  logic [DATA_WIDTH-1:0]   axi_wdata,
    input  logic [DATA_STROBES-1:0] axi_wstrb,
    input  logic                    axi_wlast,

    output logic                    axi_bvalid,
    input  logic                    axi_bready,
    output logic [1:0]              axi_bresp,
    output logic [ID_WIDTH-1:0]     axi_bid,

    input  logic                    axi_arvalid,
    output logic                    axi_arready,
    input  logic [ID_WIDTH-1:0]     axi_arid,
    input  logic [ADDR_WIDTH-1:0]   axi_araddr,
    input  logic [7:0]              axi_arlen,
    input  logic [2:0]              axi_arsize,
    input  logic [1:0]              axi_arburst,

    output logic                    axi_rvalid,
    input  logic                    axi_rready,
    output logic [1:0]              axi_rresp,
    output logic                    axi_rlast,
    output logic [DATA_WIDTH-1:0]   axi_rdata,
    output logic [ID_WIDTH-1:0]     axi_rid,

    input  logic                    address_error,
    input  logic                    write_error,
    output logic [ADDR_WIDTH-1:0]   address,
    output logic                    write,
    output logic [DATA_WIDTH-1:0]   write_data,
    output logic [DATA_STROBES-1:0] write_byteenable,
    output logic                    read,
    input  logic [DATA_WIDTH-1:0]   read_data
);

    localparam int LOG2 = $clog2(DATA_STROBES);
    localparam logic [2:0] SIZE_OK = 3'(LOG2);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WRITE_BURST,
        WRITE_RESP,
        READ_ISSUE,
        READ_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic                    prio_q, prio_d;     // 0: write wins a tie, 1: read wins
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [1:0]              burst_q, burst_d;
    logic [7:0]              count_q, count_d;
    logic                    flag_q, flag_d;     // malformed transaction
    logic [1:0]              bresp_q, bresp_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic                    rlast_q, rlast_d;

    logic                    aw_bad, ar_bad;
    logic                    last_beat;
    logic [1:0]              wr_resp;
    logic [ADDR_WIDTH-1:0]   incr_addr, wrap_mask, next_addr;

    // Malformed transactions are detected once, at address acceptance.
    assign aw_bad = (axi_awsize != SIZE_OK) || (axi_awburst == 2'b11)
                 || ((axi_awburst == 2'b10) && !(axi_awlen inside {8'd1, 8'd3, 8'd7, 8'd15}))
                 || (axi_awaddr[LOG2-1:0] != '0);
    assign ar_bad = (axi_arsize != SIZE_OK) || (axi_arburst == 2'b11)
                 || ((axi_arburst == 2'b10) && !(axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15}))
                 || (axi_araddr[LOG2-1:0] != '0);

    assign last_beat = (count_q == len_q);

    // WRAP: only the bits below the wrap boundary (burst size in bytes) move.
    assign incr_addr = addr_q + ADDR_WIDTH'(DATA_STROBES);
    assign wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << LOG2) - ADDR_WIDTH'(1);

    always_comb begin
        case (burst_q)
            2'b00:   next_addr = addr_q;
            2'b10:   next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
            default: next_addr = incr_addr;
        endcase
    end

    assign address          = addr_q;
    assign write_data       = axi_wdata;
    assign write_byteenable = axi_wstrb;
    assign axi_bresp        = bresp_q;
    assign axi_bid          = id_q;
    assign axi_rresp        = rresp_q;
    assign axi_rlast        = rlast_q;
    assign axi_rdata        = rdata_q;
    assign axi_rid          = id_q;

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        burst_d     = burst_q;
        count_d     = count_q;
        flag_d      = flag_q;
        bresp_d     = bresp_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        rlast_d     = rlast_q;
        axi_awready = 1'b0;
        axi_arready = 1'b0;
        axi_wready  = 1'b0;
        axi_bvalid  = 1'b0;
        axi_rvalid  = 1'b0;
        write       = 1'b0;
        read        = 1'b0;
        wr_resp     = RESP_OKAY;

        case (state_q)
            IDLE: begin
                axi_awready = axi_awvalid && (!axi_arvalid || !prio_q);
                axi_arready = axi_arvalid && (!axi_awvalid || prio_q);
                if (axi_awready) begin
                    id_d    = axi_awid;
                    addr_d  = axi_awaddr;
                    len_d   = axi_awlen;
                    burst_d = axi_awburst;
                    flag_d  = aw_bad;
                    count_d = 8'd0;
                    bresp_d = RESP_OKAY;
                    prio_d  = !prio_q;
                    state_d = WRITE_BURST;
                end else if (axi_arready) begin
                    id_d    = axi_arid;
                    addr_d  = axi_araddr;
                    len_d   = axi_arlen;
                    burst_d = axi_arburst;
                    flag_d  = ar_bad;
                    count_d = 8'd0;
                    prio_d  = !prio_q;
                    state_d = READ_ISSUE;
                end
            end

            WRITE_BURST: begin
                axi_wready = 1'b1;
                if (axi_wvalid) begin
                    write = !flag_q;
                    if (address_error)
                        wr_resp = RESP_DECERR;
                    else if (write_error || flag_q || (axi_wlast != last_beat))
                        wr_resp = RESP_SLVERR;
                    // Response encodings order numerically by severity.
                    if (wr_resp > bresp_q)
                        bresp_d = wr_resp;
                    addr_d = next_addr;
                    if (last_beat)
                        state_d = WRITE_RESP;
                    else
                        count_d = count_q + 8'd1;
                end
            end

            WRITE_RESP: begin
                axi_bvalid = 1'b1;
                if (axi_bready)
                    state_d = IDLE;
            end

            READ_ISSUE: begin
                read    = !flag_q;
                rdata_d = (address_error || flag_q) ? '0 : read_data;
                if (address_error)
                    rresp_d = RESP_DECERR;
                else if (flag_q)
                    rresp_d = RESP_SLVERR;
                else
                    rresp_d = RESP_OKAY;
                rlast_d = last_beat;
                state_d = READ_RESP;
            end

            READ_RESP: begin
                axi_rvalid = 1'b1;
                if (axi_rready) begin
                    if (rlast_q) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = next_addr;
                        count_d = count_q + 8'd1;
                        state_d = READ_ISSUE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            burst_q <= '0;
            count_q <= '0;
            flag_q  <= 1'b0;
            bresp_q <= RESP_OKAY;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
            rlast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            burst_q <= burst_d;
            count_q <= count_d;
            flag_q  <= flag_d;
            bresp_q <= bresp_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
            rlast_q <= rlast_d;
        end
    end

endmodule

// File: tb/tb_armleocpu_axi2simple_burst_converter.sv
// Self-checking bench for armleocpu_axi2simple_burst_converter.
// Directed scenarios followed by randomized bursts, all compared against a
// behavioural model of burst addressing and response rules.
module tb_armleocpu_axi2simple_burst_converter;
    localparam int AW  = 34;
    localparam int IW  = 4;
    localparam int DW  = 32;
    localparam int DS  = DW / 8;
    localparam int TMO = 300;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           axi_awvalid = 0, axi_awready;
    logic [IW-1:0]  axi_awid = 0;
    logic [AW-1:0]  axi_awaddr = 0;
    logic [7:0]     axi_awlen = 0;
    logic [2:0]     axi_awsize = 0;
    logic [1:0]     axi_awburst = 0;
    logic           axi_wvalid = 0, axi_wready;
    logic [DW-1:0]  axi_wdata = 0;
    logic [DS-1:0]  axi_wstrb = 0;
    logic           axi_wlast = 0;
    logic           axi_bvalid, axi_bready = 0;
    logic [1:0]     axi_bresp;
    logic [IW-1:0]  axi_bid;
    logic           axi_arvalid = 0, axi_arready;
    logic [IW-1:0]  axi_arid = 0;
    logic [AW-1:0]  axi_araddr = 0;
    logic [7:0]     axi_arlen = 0;
    logic [2:0]     axi_arsize = 0;
    logic [1:0]     axi_arburst = 0;
    logic           axi_rvalid, axi_rready = 0;
    logic [1:0]     axi_rresp;
    logic           axi_rlast;
    logic [DW-1:0]  axi_rdata;
    logic [IW-1:0]  axi_rid;
    logic           address_error, write_error;
    logic [AW-1:0]  address;
    logic           write, read;
    logic [DW-1:0]  write_data, read_data;
    logic [DS-1:0]  write_byteenable;

    armleocpu_axi2simple_burst_converter #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awid(axi_awid),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp), .axi_bid(axi_bid),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rdata(axi_rdata), .axi_rid(axi_rid),
        .address_error(address_error), .write_error(write_error), .address(address),
        .write(write), .write_data(write_data), .write_byteenable(write_byteenable),
        .read(read), .read_data(read_data)
    );

    // Peripheral model: data is a hash of the address; errors at chosen addresses.
    logic          ae_en = 0, we_en = 0;
    logic [AW-1:0] ae_addr = 0, we_addr = 0;
    function automatic logic [DW-1:0] mem_val(logic [AW-1:0] a);
        return (a[31:0] * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction
    assign address_error = ae_en && (address == ae_addr);
    assign write_error   = we_en && (address == we_addr);
    assign read_data     = mem_val(address);

    // Bus monitor, sampled mid-cycle.
    logic [AW-1:0] wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];
    logic [DS-1:0] wr_be_q[$];
    logic [AW-1:0] rd_addr_q[$];
    byte           ord_q[$];
    always @(negedge clk) begin
        if (write) begin
            wr_addr_q.push_back(address);
            wr_data_q.push_back(write_data);
            wr_be_q.push_back(write_byteenable);
        end
        if (read) rd_addr_q.push_back(address);
        if (axi_awvalid && axi_awready) ord_q.push_back("W");
        if (axi_arvalid && axi_arready) ord_q.push_back("R");
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: address of beat i, from the AXI burst rules.
    function automatic logic [AW-1:0] beat_addr(logic [AW-1:0] a, logic [1:0] burst, int len, int i);
        logic [AW-1:0] wb, base;
        case (burst)
            2'b00: return a;
            2'b10: begin
                wb   = AW'((len + 1) * DS);
                base = a - (a % wb);
                return base + ((a - base + AW'(i * DS)) % wb);
            end
            default: return a + AW'(i * DS);
        endcase
    endfunction

    function automatic bit is_bad(logic [2:0] size, logic [1:0] burst, int len, logic [AW-1:0] a);
        return (size != 3'($clog2(DS))) || (burst == 2'b11)
            || (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15))
            || ((a % DS) != 0);
    endfunction

    // All transaction tasks are entered and left one time unit after a rising edge.
    task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] a, input int len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int bad_wlast_beat, input string tag);
        logic [DW-1:0] d[$];
        logic [DS-1:0] be[$];
        logic [1:0]    exp_b, r;
        logic [AW-1:0] ba;
        bit            flagged;
        int            n;
        flagged = is_bad(size, burst, len, a);
        for (int i = 0; i <= len; i++) begin
            d.push_back($urandom);
            be.push_back(DS'($urandom));
        end
        wr_addr_q.delete(); wr_data_q.delete(); wr_be_q.delete();
        axi_awvalid = 1; axi_awid = id; axi_awaddr = a; axi_awlen = 8'(len);
        axi_awsize = size; axi_awburst = burst;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi_awready && n < TMO);
        chk({tag, "_awready"}, axi_awready, 1);
        @(posedge clk); #1;
        axi_awvalid = 0;
        exp_b = 2'b00;
        for (int i = 0; i <= len; i++) begin
            axi_wvalid = 1; axi_wdata = d[i]; axi_wstrb = be[i];
            axi_wlast = (i == len) ^ (i == bad_wlast_beat);
            ba = beat_addr(a, burst, len, i);
            if (ae_en && ba == ae_addr) r = 2'b11;
            else if ((we_en && ba == we_addr) || flagged || i == bad_wlast_beat) r = 2'b10;
            else r = 2'b00;
            if (r > exp_b) exp_b = r;
            n = 0;
            do begin @(negedge clk); n++; end while (!axi_wready && n < TMO);
            chk({tag, "_wready"}, axi_wready, 1);
            @(posedge clk); #1;
        end
        axi_wvalid = 0; axi_wlast = 0;
        axi_bready = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi_bvalid && n < TMO);
        chk({tag, "_bvalid"}, axi_bvalid, 1);
        chk({tag, "_bresp"}, axi_bresp, exp_b);
        chk({tag, "_bid"}, axi_bid, id);
        @(posedge clk); #1;
        axi_bready = 0;
        chk({tag, "_wr_pulses"}, wr_addr_q.size(), flagged ? 0 : len + 1);
        for (int i = 0; i < wr_addr_q.size() && i <= len && !flagged; i++) begin
            chk({tag, "_wr_addr"}, wr_addr_q[i], beat_addr(a, burst, len, i));
            chk({tag, "_wr_data"}, wr_data_q[i], d[i]);
            chk({tag, "_wr_be"}, wr_be_q[i], be[i]);
        end
    endtask

    task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] a, input int len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int stall_beat, input int stall_cycles, input string tag);
        logic [AW-1:0] ba;
        logic [DW-1:0] exp_d;
        logic [1:0]    exp_r;
        bit            flagged, dec;
        int            n, nb;
        flagged = is_bad(size, burst, len, a);
        rd_addr_q.delete();
        axi_arvalid = 1; axi_arid = id; axi_araddr = a; axi_arlen = 8'(len);
        axi_arsize = size; axi_arburst = burst;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi_arready && n < TMO);
        chk({tag, "_arready"}, axi_arready, 1);
        @(posedge clk); #1;
        axi_arvalid = 0;
        for (int i = 0; i <= len; i++) begin
            ba    = beat_addr(a, burst, len, i);
            dec   = ae_en && (ba == ae_addr);
            exp_r = dec ? 2'b11 : (flagged ? 2'b10 : 2'b00);
            exp_d = (dec || flagged) ? '0 : mem_val(ba);
            axi_rready = (i != stall_beat);
            n = 0;
            do begin @(negedge clk); n++; end while (!axi_rvalid && n < TMO);
            chk({tag, "_rvalid"}, axi_rvalid, 1);
            chk({tag, "_rdata"}, axi_rdata, exp_d);
            chk({tag, "_rresp"}, axi_rresp, exp_r);
            chk({tag, "_rlast"}, axi_rlast, i == len);
            chk({tag, "_rid"}, axi_rid, id);
            if (i == stall_beat) begin
                nb = rd_addr_q.size();
                repeat (stall_cycles) begin
                    @(posedge clk); #1;
                    @(negedge clk);
                    chk({tag, "_stall_rvalid"}, axi_rvalid, 1);
                    chk({tag, "_stall_rdata"}, axi_rdata, exp_d);
                    chk({tag, "_stall_rresp"}, axi_rresp, exp_r);
                    chk({tag, "_stall_rlast"}, axi_rlast, i == len);
                end
                chk({tag, "_stall_noread"}, rd_addr_q.size(), nb);
                @(posedge clk); #1;
                axi_rready = 1;
                @(negedge clk);
            end
            @(posedge clk); #1;
        end
        axi_rready = 0;
        chk({tag, "_rd_pulses"}, rd_addr_q.size(), flagged ? 0 : len + 1);
        for (int i = 0; i < rd_addr_q.size() && i <= len && !flagged; i++)
            chk({tag, "_rd_addr"}, rd_addr_q[i], beat_addr(a, burst, len, i));
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        int n;
        bit bv_seen;
        string ord;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", axi_awready, 0);
        chk("rst_arready", axi_arready, 0);
        chk("rst_wready", axi_wready, 0);
        chk("rst_bvalid", axi_bvalid, 0);
        chk("rst_rvalid", axi_rvalid, 0);
        chk("rst_write", write, 0);
        chk("rst_read", read, 0);
        chk("rst_bresp", axi_bresp, 0);
        chk("rst_rresp", axi_rresp, 0);
        chk("rst_rlast", axi_rlast, 0);
        chk("rst_rdata", axi_rdata, 0);
        chk("rst_bid", axi_bid, 0);
        chk("rst_rid", axi_rid, 0);
        @(posedge clk); #1 rst_n = 1;

        // Single write, then reads of various shapes
        do_write(4'd5, 34'h10, 0, 3'd2, 2'b01, -1, "single_wr");
        do_read(4'd3, 34'h20, 3, 3'd2, 2'b01, -1, 0, "incr_rd");
        do_read(4'd6, 34'h18, 3, 3'd2, 2'b10, -1, 0, "wrap_rd");
        do_read(4'd7, 34'h18, 2, 3'd2, 2'b10, -1, 0, "wrap_bad_len");
        do_read(4'd1, 34'h40, 2, 3'd2, 2'b00, -1, 0, "fixed_rd");
        do_read(4'd2, 34'h41, 0, 3'd2, 2'b01, -1, 0, "misaligned_rd");
        do_write(4'd2, 34'h80, 1, 3'd3, 2'b01, -1, "bad_size_wr");
        do_write(4'd9, 34'h90, 1, 3'd2, 2'b11, -1, "reserved_burst_wr");
        do_write(4'd4, 34'h30, 7, 3'd2, 2'b10, -1, "wrap_wr");
        do_write(4'd8, '0 - AW'(8), 3, 3'd2, 2'b01, -1, "incr_wrap_top");

        // Error accumulation
        ae_en = 1; ae_addr = 34'h104; we_en = 1; we_addr = 34'h108;
        do_write(4'd1, 34'h100, 3, 3'd2, 2'b01, -1, "acc_dec");
        ae_en = 0; we_en = 0;
        do_write(4'd1, 34'h100, 3, 3'd2, 2'b01, 3, "missing_wlast");
        do_write(4'd1, 34'h100, 3, 3'd2, 2'b01, 1, "early_wlast");
        ae_en = 1; ae_addr = 34'h204;
        do_read(4'd3, 34'h200, 2, 3'd2, 2'b01, -1, 0, "rd_decerr");
        ae_en = 0;

        // Read backpressure
        do_read(4'd5, 34'h300, 3, 3'd2, 2'b01, 1, 5, "rd_stall");

        // Arbitration from reset: both channels keep requesting
        do_reset();
        ord_q.delete();
        fork
            begin
                do_write(4'd1, 34'h400, 1, 3'd2, 2'b01, -1, "arb_wr0");
                do_write(4'd2, 34'h410, 0, 3'd2, 2'b01, -1, "arb_wr1");
            end
            begin
                do_read(4'd3, 34'h500, 1, 3'd2, 2'b01, -1, 0, "arb_rd0");
                do_read(4'd4, 34'h510, 0, 3'd2, 2'b01, -1, 0, "arb_rd1");
            end
        join
        ord = "";
        foreach (ord_q[i]) ord = {ord, string'(ord_q[i])};
        chk("arb_count", ord_q.size(), 4);
        chk("arb_order", (ord == "WRWR") ? 1 : 0, 1);

        // Reset in the middle of a write burst
        axi_awvalid = 1; axi_awid = 4'd7; axi_awaddr = 34'h600; axi_awlen = 8'd3;
        axi_awsize = 3'd2; axi_awburst = 2'b01;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi_awready && n < TMO);
        chk("mid_rst_awready", axi_awready, 1);
        @(posedge clk); #1;
        axi_awvalid = 0;
        axi_wvalid = 1; axi_wdata = 32'h1234_5678; axi_wstrb = 4'hF; axi_wlast = 0;
        repeat (2) begin
            @(negedge clk);
            chk("mid_rst_wready", axi_wready, 1);
            @(posedge clk); #1;
        end
        axi_wvalid = 0;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("mid_rst_idle_wready", axi_wready, 0);
        bv_seen = axi_bvalid;
        repeat (8) begin
            @(negedge clk);
            if (axi_bvalid) bv_seen = 1;
        end
        chk("mid_rst_no_b", bv_seen, 0);
        @(posedge clk); #1;
        do_write(4'd6, 34'h700, 0, 3'd2, 2'b01, -1, "post_rst_wr");

        // Randomized bursts
        for (int t = 0; t < 40; t++) begin
            logic [AW-1:0] a;
            logic [1:0]    burst;
            logic [2:0]    size;
            int            len, k;
            burst = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 19) == 0) burst = 2'b11;
            if (burst == 2'b10) begin
                k = $urandom_range(0, 4);
                len = (k == 4) ? $urandom_range(0, 6) : ((2 << k) - 1);
            end else begin
                len = $urandom_range(0, 7);
            end
            size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            if ($urandom_range(0, 7) == 0)
                a = '0 - AW'($urandom_range(1, 8) * DS);
            else
                a = AW'($urandom_range(0, 1023) * DS);
            if ($urandom_range(0, 9) == 0) a = a + AW'($urandom_range(1, DS - 1));
            if ($urandom_range(0, 1) == 0)
                do_write(IW'($urandom), a, len, size, burst,
                         ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1, "rnd_wr");
            else
                do_read(IW'($urandom), a, len, size, burst,
                        ($urandom_range(0, 2) == 0) ? $urandom_range(0, len) : -1,
                        $urandom_range(1, 4), "rnd_rd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
